// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared AXI4-Lite response codes and read-FSM encodings.
package axi_lite_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_RESP} r_state_t;
endpackage

// File: rtl/axi_lite_slave_adapter_if.sv
// axi_lite_slave_adapter_if: AXI4-Lite bus bundle with master/slave views.
interface axi_lite_slave_adapter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   S_AXI_AWADDR;
    logic [2:0]          S_AXI_AWPROT;
    logic                S_AXI_AWVALID;
    logic                S_AXI_AWREADY;
    logic [DATA_W-1:0]   S_AXI_WDATA;
    logic [DATA_W/8-1:0] S_AXI_WSTRB;
    logic                S_AXI_WVALID;
    logic                S_AXI_WREADY;
    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY;
    logic [ADDR_W-1:0]   S_AXI_ARADDR;
    logic [2:0]          S_AXI_ARPROT;
    logic                S_AXI_ARVALID;
    logic                S_AXI_ARREADY;
    logic [DATA_W-1:0]   S_AXI_RDATA;
    logic [1:0]          S_AXI_RRESP;
    logic                S_AXI_RVALID;
    logic                S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/axi_lite_resp_fifo.sv
// axi_lite_resp_fifo: small synchronous FIFO holding queued write responses.
module axi_lite_resp_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp, rp;
    logic             do_push, do_pop;

    assign full    = count == (PW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rp];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + PW'(do_push);
            rp    <= rp + PW'(do_pop);
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end

    always_ff @(posedge clk)
        if (do_push) mem[wp] <= din;
endmodule

// File: rtl/axi_lite_slave_adapter.sv
// axi_lite_slave_adapter: AXI4-Lite slave that decodes a window and forwards
// accesses to a simple registered valid/ready user port.
module axi_lite_slave_adapter
    import axi_lite_pkg::*;
#(
    parameter int              C_S_AXI_ADDR_WIDTH = 32,
    parameter int              C_S_AXI_DATA_WIDTH = 32,
    parameter longint unsigned C_BASE_ADDR        = 0,
    parameter longint unsigned C_ADDR_SPAN        = 4096,
    parameter int              C_B_DEPTH          = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    axi_lite_slave_adapter_if.slave         s_axi,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]   waddr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   wdata,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb,
    output logic                            wvalid,
    input  logic                            wready,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]   araddr,
    output logic                            arvalid,
    input  logic                            arready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   rdata,
    input  logic                            rerr,
    input  logic                            rvalid,
    output logic                            rready
);
    localparam int              AW   = C_S_AXI_ADDR_WIDTH;
    localparam int              DW   = C_S_AXI_DATA_WIDTH;
    localparam int              CW   = $clog2(C_B_DEPTH) + 1;
    localparam logic [AW:0]     LO   = (AW+1)'(C_BASE_ADDR);
    localparam logic [AW:0]     SPAN = (AW+1)'(C_ADDR_SPAN);
    localparam logic [AW-1:0]   BASE = AW'(C_BASE_ADDR);

    // One extra bit: a borrow marks addr < base, and base+span never wraps.
    function automatic logic in_range(input logic [AW-1:0] a);
        logic [AW:0] d;
        d = {1'b0, a} - LO;
        return !d[AW] && (d < SPAN);
    endfunction

    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge ACLK or negedge ARESETN)
        if (!ARESETN) rst_sync <= '0;
        else          rst_sync <= {rst_sync[0], 1'b1};

    assign rst_n = rst_sync[1];

    logic            aw_full, w_full, aw_ok, wr_decerr;
    logic [AW-1:0]   aw_addr;
    logic [DW-1:0]   w_data;
    logic [DW/8-1:0] w_strb;
    logic [CW-1:0]   b_count;
    logic [CW:0]     b_occ;
    logic            b_room, b_push, b_pop, b_empty, b_full;
    logic [1:0]      b_head;

    // A complete pair waiting in the holders has a response slot reserved.
    assign aw_ok     = in_range(aw_addr);
    assign b_occ     = {1'b0, b_count} + (CW+1)'(aw_full & w_full);
    assign b_room    = b_occ < (CW+1)'(C_B_DEPTH);
    assign wr_decerr = aw_full & w_full & ~aw_ok;
    assign b_push    = (wvalid & wready) | wr_decerr;
    assign b_pop     = ~b_empty & s_axi.S_AXI_BREADY;

    assign s_axi.S_AXI_AWREADY = rst_n & ~aw_full & b_room;
    assign s_axi.S_AXI_WREADY  = rst_n & ~w_full & b_room;
    assign s_axi.S_AXI_BVALID  = ~b_empty;
    assign s_axi.S_AXI_BRESP   = b_head;

    assign waddr = aw_addr - BASE;
    assign wdata = w_data;
    assign wstrb = w_strb;

    always_ff @(posedge ACLK or negedge rst_n)
        if (!rst_n) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            wvalid  <= 1'b0;
            aw_addr <= '0;
            w_data  <= '0;
            w_strb  <= '0;
        end else begin
            if (s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY) begin
                aw_full <= 1'b1;
                aw_addr <= s_axi.S_AXI_AWADDR;
            end
            if (s_axi.S_AXI_WVALID && s_axi.S_AXI_WREADY) begin
                w_full <= 1'b1;
                w_data <= s_axi.S_AXI_WDATA;
                w_strb <= s_axi.S_AXI_WSTRB;
            end
            if (b_push) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                wvalid  <= 1'b0;
            end else if (aw_full && w_full && aw_ok) begin
                wvalid <= 1'b1;
            end
        end

    axi_lite_resp_fifo #(
        .WIDTH(2),
        .DEPTH(C_B_DEPTH)
    ) u_b_fifo (
        .clk  (ACLK),
        .rst_n(rst_n),
        .push (b_push),
        .din  (wvalid ? RESP_OKAY : RESP_DECERR),
        .pop  (b_pop),
        .dout (b_head),
        .full (b_full),
        .empty(b_empty),
        .count(b_count)
    );

    r_state_t      r_state, r_next;
    logic [AW-1:0] ar_addr;
    logic [DW-1:0] r_data;
    logic [1:0]    r_resp;

    always_ff @(posedge ACLK or negedge rst_n)
        if (!rst_n) r_state <= R_IDLE;
        else        r_state <= r_next;

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (s_axi.S_AXI_ARVALID) r_next = in_range(s_axi.S_AXI_ARADDR) ? R_ADDR : R_RESP;
            R_ADDR:  if (arready) r_next = R_DATA;
            R_DATA:  if (rvalid) r_next = R_RESP;
            R_RESP:  if (s_axi.S_AXI_RREADY) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // DECERR with zero data is preloaded; in-range reads overwrite it from the user side.
    always_ff @(posedge ACLK or negedge rst_n)
        if (!rst_n) begin
            ar_addr <= '0;
            r_data  <= '0;
            r_resp  <= RESP_OKAY;
        end else begin
            if (r_state == R_IDLE && s_axi.S_AXI_ARVALID) begin
                ar_addr <= s_axi.S_AXI_ARADDR;
                r_data  <= '0;
                r_resp  <= RESP_DECERR;
            end
            if (r_state == R_DATA && rvalid) begin
                r_data <= rdata;
                r_resp <= rerr ? RESP_SLVERR : RESP_OKAY;
            end
        end

    assign araddr              = ar_addr - BASE;
    assign arvalid             = r_state == R_ADDR;
    assign rready              = r_state == R_DATA;
    assign s_axi.S_AXI_ARREADY = rst_n & (r_state == R_IDLE);
    assign s_axi.S_AXI_RVALID  = r_state == R_RESP;
    assign s_axi.S_AXI_RDATA   = r_data;
    assign s_axi.S_AXI_RRESP   = r_resp;

    logic unused;
    assign unused = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, b_full};
endmodule

// File: tb/tb_axi_lite_slave_adapter.sv
// tb_axi_lite_slave_adapter: directed vector bench for the AXI4-Lite adapter.
module tb_axi_lite_slave_adapter;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] waddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready, arvalid, arready, rerr, rvalid, rready;

    always #5 clk = ~clk;

    axi_lite_slave_adapter_if s ();

    axi_lite_slave_adapter dut (
        .ACLK   (clk),
        .ARESETN(aresetn),
        .s_axi  (s),
        .waddr  (waddr),
        .wdata  (wdata),
        .wstrb  (wstrb),
        .wvalid (wvalid),
        .wready (wready),
        .araddr (araddr),
        .arvalid(arvalid),
        .arready(arready),
        .rdata  (rdata),
        .rerr   (rerr),
        .rvalid (rvalid),
        .rready (rready)
    );

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    int          wr_cnt = 0, ar_cnt = 0;
    logic [31:0] last_waddr, last_wdata, last_araddr;
    logic [3:0]  last_wstrb;
    logic [31:0] wq[$];

    always @(negedge clk) begin
        if (wvalid && wready) begin
            wr_cnt++;
            last_waddr = waddr;
            last_wdata = wdata;
            last_wstrb = wstrb;
            wq.push_back(waddr);
        end
        if (arvalid && arready) begin
            ar_cnt++;
            last_araddr = araddr;
        end
    end

    task automatic start_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
        s.S_AXI_AWADDR  = a;
        s.S_AXI_WDATA   = d;
        s.S_AXI_WSTRB   = st;
        s.S_AXI_AWVALID = 1'b1;
        s.S_AXI_WVALID  = 1'b1;
    endtask

    task automatic finish_write(input string tag);
        int n = 0;
        bit aw_go, w_go;
        while ((s.S_AXI_AWVALID || s.S_AXI_WVALID) && n < 60) begin
            aw_go = s.S_AXI_AWVALID && s.S_AXI_AWREADY;
            w_go  = s.S_AXI_WVALID && s.S_AXI_WREADY;
            @(negedge clk);
            if (aw_go) s.S_AXI_AWVALID = 1'b0;
            if (w_go) s.S_AXI_WVALID = 1'b0;
            n++;
        end
        chk({tag, " aw/w pending"}, {s.S_AXI_AWVALID, s.S_AXI_WVALID}, 0);
        s.S_AXI_AWVALID = 1'b0;
        s.S_AXI_WVALID  = 1'b0;
    endtask

    task automatic get_b(input string tag, output logic [1:0] resp);
        int n = 0;
        while (!s.S_AXI_BVALID && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " bvalid"}, s.S_AXI_BVALID, 1);
        resp = s.S_AXI_BRESP;
        @(negedge clk);
    endtask

    task automatic do_read(input string tag, input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        int n = 0;
        s.S_AXI_ARADDR  = a;
        s.S_AXI_ARVALID = 1'b1;
        while (!s.S_AXI_ARREADY && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " arready"}, s.S_AXI_ARREADY, 1);
        @(negedge clk);
        s.S_AXI_ARVALID = 1'b0;
        n = 0;
        while (!s.S_AXI_RVALID && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " rvalid"}, s.S_AXI_RVALID, 1);
        d = s.S_AXI_RDATA;
        r = s.S_AXI_RRESP;
        @(negedge clk);
    endtask

    typedef struct {
        bit          rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        bit          err;
        logic [1:0]  resp;
        logic [31:0] exp_d;
        bit          usr;
    } vec_t;

    vec_t v[10];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0]  r;
        logic [31:0] d;
        int          c0, q0, got, n;

        v[0] = '{0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, OKAY,   32'h0,         1};
        v[1] = '{0, 32'h0000_0000, 32'h1111_2222, 4'h3, 0, OKAY,   32'h0,         1};
        v[2] = '{0, 32'h0000_0FFC, 32'h0BAD_F00D, 4'h8, 0, OKAY,   32'h0,         1};
        v[3] = '{0, 32'h0000_1000, 32'h3333_3333, 4'hF, 0, DECERR, 32'h0,         0};
        v[4] = '{0, 32'hFFFF_FFFC, 32'h4444_4444, 4'hF, 0, DECERR, 32'h0,         0};
        v[5] = '{1, 32'h0000_0020, 32'h0000_1234, 4'h0, 0, OKAY,   32'h0000_1234, 1};
        v[6] = '{1, 32'h0000_0024, 32'h0000_0BAD, 4'h0, 1, SLVERR, 32'h0000_0BAD, 1};
        v[7] = '{1, 32'hFFFF_FFFC, 32'h5555_5555, 4'h0, 0, DECERR, 32'h0,         0};
        v[8] = '{1, 32'h0000_1000, 32'h0000_0777, 4'h0, 0, DECERR, 32'h0,         0};
        v[9] = '{1, 32'h0000_0FFC, 32'hCAFE_F00D, 4'h0, 0, OKAY,   32'hCAFE_F00D, 1};

        s.S_AXI_AWADDR = '0; s.S_AXI_AWPROT = '0; s.S_AXI_AWVALID = 1'b0;
        s.S_AXI_WDATA = '0; s.S_AXI_WSTRB = '0; s.S_AXI_WVALID = 1'b0;
        s.S_AXI_BREADY = 1'b1;
        s.S_AXI_ARADDR = '0; s.S_AXI_ARPROT = '0; s.S_AXI_ARVALID = 1'b0;
        s.S_AXI_RREADY = 1'b1;
        wready = 1'b1; arready = 1'b1; rdata = '0; rerr = 1'b0; rvalid = 1'b1;

        // Reset state, held and released.
        repeat (3) @(negedge clk);
        chk("rst awready", s.S_AXI_AWREADY, 0);
        chk("rst wready", s.S_AXI_WREADY, 0);
        chk("rst arready", s.S_AXI_ARREADY, 0);
        chk("rst bvalid", s.S_AXI_BVALID, 0);
        chk("rst rvalid", s.S_AXI_RVALID, 0);
        chk("rst user valids", {wvalid, arvalid, rready}, 0);
        aresetn = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle awready", s.S_AXI_AWREADY, 1);
        chk("idle wready", s.S_AXI_WREADY, 1);
        chk("idle arready", s.S_AXI_ARREADY, 1);
        chk("idle bvalid", s.S_AXI_BVALID, 0);

        // Write latency and stability under user backpressure.
        @(posedge clk); #1 wready = 1'b0;
        @(negedge clk);
        c0 = wr_cnt;
        start_write(32'h10, 32'hDEAD_BEEF, 4'hF);
        @(negedge clk);
        s.S_AXI_AWVALID = 1'b0; s.S_AXI_WVALID = 1'b0;
        chk("lat wvalid early", wvalid, 0);
        @(negedge clk);
        chk("lat wvalid", wvalid, 1);
        chk("lat waddr", waddr, 32'h10);
        chk("lat wdata", wdata, 32'hDEAD_BEEF);
        chk("lat wstrb", wstrb, 4'hF);
        repeat (2) @(negedge clk);
        chk("hold wvalid", wvalid, 1);
        chk("hold waddr", waddr, 32'h10);
        @(posedge clk); #1 wready = 1'b1;
        get_b("lat", r);
        chk("lat bresp", r, OKAY);
        chk("lat user writes", wr_cnt - c0, 1);

        // W arrives three cycles ahead of AW.
        c0 = wr_cnt;
        s.S_AXI_WDATA = 32'h0000_55AA; s.S_AXI_WSTRB = 4'hC; s.S_AXI_WVALID = 1'b1;
        @(negedge clk);
        s.S_AXI_WVALID = 1'b0;
        repeat (2) @(negedge clk);
        chk("wfirst no wvalid", wvalid, 0);
        chk("wfirst no bvalid", s.S_AXI_BVALID, 0);
        s.S_AXI_AWADDR = 32'h44; s.S_AXI_AWVALID = 1'b1;
        @(negedge clk);
        s.S_AXI_AWVALID = 1'b0;
        get_b("wfirst", r);
        chk("wfirst bresp", r, OKAY);
        chk("wfirst waddr", last_waddr, 32'h44);
        chk("wfirst wdata", last_wdata, 32'h0000_55AA);
        chk("wfirst wstrb", last_wstrb, 4'hC);
        repeat (5) @(negedge clk);
        chk("wfirst one bvalid", s.S_AXI_BVALID, 0);
        chk("wfirst user writes", wr_cnt - c0, 1);

        // Reset asserted while the read waits in R_DATA.
        rvalid = 1'b0;
        c0 = ar_cnt;
        s.S_AXI_ARADDR = 32'h30; s.S_AXI_ARVALID = 1'b1;
        @(negedge clk);
        s.S_AXI_ARVALID = 1'b0;
        chk("rd lat arvalid", arvalid, 1);
        chk("rd araddr", araddr, 32'h30);
        @(negedge clk);
        chk("rd in R_DATA", rready, 1);
        repeat (2) @(negedge clk);
        aresetn = 1'b0;
        #1;
        chk("mid rst rvalid", s.S_AXI_RVALID, 0);
        chk("mid rst arready", s.S_AXI_ARREADY, 0);
        chk("mid rst rready", rready, 0);
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        repeat (3) @(negedge clk);
        chk("post rst arready", s.S_AXI_ARREADY, 1);
        chk("post rst rvalid", s.S_AXI_RVALID, 0);
        rvalid = 1'b1;
        repeat (4) @(negedge clk);
        chk("post rst no stale r", s.S_AXI_RVALID, 0);
        chk("post rst rready", rready, 0);
        chk("post rst ar count", ar_cnt - c0, 1);

        // Vector table.
        for (int i = 0; i < 10; i++) begin
            if (v[i].rd) begin
                rdata = v[i].data;
                rerr  = v[i].err;
                c0    = ar_cnt;
                do_read($sformatf("v%0d", i), v[i].addr, d, r);
                chk($sformatf("v%0d rresp", i), r, v[i].resp);
                chk($sformatf("v%0d rdata", i), d, v[i].exp_d);
                chk($sformatf("v%0d user reads", i), ar_cnt - c0, v[i].usr);
                if (v[i].usr) chk($sformatf("v%0d araddr", i), last_araddr, v[i].addr);
            end else begin
                c0 = wr_cnt;
                start_write(v[i].addr, v[i].data, v[i].strb);
                finish_write($sformatf("v%0d", i));
                get_b($sformatf("v%0d", i), r);
                chk($sformatf("v%0d bresp", i), r, v[i].resp);
                chk($sformatf("v%0d user writes", i), wr_cnt - c0, v[i].usr);
                if (v[i].usr) begin
                    chk($sformatf("v%0d waddr", i), last_waddr, v[i].addr);
                    chk($sformatf("v%0d wdata", i), last_wdata, v[i].data);
                    chk($sformatf("v%0d wstrb", i), last_wstrb, v[i].strb);
                end
            end
        end
        rerr = 1'b0;

        // B backpressure: four responses fill the FIFO, the fifth write stalls.
        s.S_AXI_BREADY = 1'b0;
        c0 = wr_cnt;
        q0 = wq.size();
        for (int i = 0; i < 4; i++) begin
            start_write(32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF);
            finish_write($sformatf("bp%0d", i));
        end
        start_write(32'h110, 32'hA4, 4'hF);
        repeat (10) @(negedge clk);
        chk("bp5 awready", s.S_AXI_AWREADY, 0);
        chk("bp5 wready", s.S_AXI_WREADY, 0);
        chk("bp bvalid", s.S_AXI_BVALID, 1);
        chk("bp user writes", wr_cnt - c0, 4);
        got = 0;
        fork
            finish_write("bp4");
            begin
                s.S_AXI_BREADY = 1'b1;
                n = 0;
                while (got < 5 && n < 100) begin
                    if (s.S_AXI_BVALID) begin
                        chk($sformatf("bp drain %0d bresp", got), s.S_AXI_BRESP, OKAY);
                        got++;
                    end
                    @(negedge clk);
                    n++;
                end
            end
        join
        chk("bp drained", got, 5);
        chk("bp user writes all", wr_cnt - c0, 5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("bp order %0d", i), wq[q0 + i], 32'h100 + 32'(4 * i));
        repeat (3) @(negedge clk);
        chk("bp empty", s.S_AXI_BVALID, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
